reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Consumes clk and clk_ok from the PLL clock generator and produces the single system reset.
//  Merges four reset sources into one glitch-free, minimum-length, registered reset:
//   - PLL lock loss
//   - debounced board pushbutton
//   - watchdog trigger
//   - software request
//  Records the cause of the last reset for the boot code.
// PARAMETERS
//  HOLD_CYCLES      16     min cycles rst_out stays high after all sources clear (>=2)
//  DEBOUNCE_CYCLES  20000  cycles button input must be stable to change state (1 ms at 20 MHz)
//  SYNC_STAGES      2      synchronizer depth for clk_ok and btn_rst_n (>=2)
// PORTS
//  clk        in   1  system clock (PLL outclk 0)
//  rst        in   1  power-on reset; synchronous, active-high
//  clk_ok     in   1  PLL locked; asynchronous to clk
//  btn_rst_n  in   1  reset pushbutton; active-low, asynchronous, bouncing
//  wd_trig    in   1  watchdog expiry; 1-cycle pulse, clk domain
//  sw_rst     in   1  software reset request; 1-cycle pulse, clk domain
//  rst_out    out  1  system reset; active-high, registered
//  running    out  1  high only in state RUN
//  rst_cause  out  3  last cause: 0=POR 1=LOCK 2=BTN 3=WD 4=SW; others unused
// BEHAVIOUR
//  Reset:
//   - One clock; reset is synchronous and active-high: rst sampled on posedge clk.
//   - rst=1 -> state WAIT_LOCK, rst_out=1, running=0, rst_cause=0.
//   - rst=1 also clears synchronizers to 0, sets debounced button to released, zeroes counters.
//   - rst asserted mid-operation: same result on the next edge, in any state.
//  Synchronizers:
//   - clk_ok -> lock_s; ~btn_rst_n -> btn_s; each SYNC_STAGES flops.
//  Debounce:
//   - Counter cleared whenever btn_s == btn_db.
//   - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 btn_db <= btn_s and the counter clears.
//   - btn_press = 1-cycle pulse on the btn_db 0->1 transition.
//  FSM (states WAIT_LOCK, HOLD, RUN):
//   WAIT_LOCK:
//    - rst_out=1.
//    - lock_s=1 -> HOLD, hold_cnt <= HOLD_CYCLES-1.
//   HOLD:
//    - rst_out=1.
//    - lock_s=0 -> WAIT_LOCK.
//    - btn_db=1, wd_trig or sw_rst -> reload hold_cnt; button held keeps reset held.
//    - Otherwise decrement hold_cnt; hold_cnt==0 -> RUN.
//   RUN:
//    - rst_out=0, running=1.
//    - Events, highest priority first:
//      lock_s=0  -> WAIT_LOCK, cause 1.
//      btn_press -> HOLD,      cause 2.
//      wd_trig   -> HOLD,      cause 3.
//      sw_rst    -> HOLD,      cause 4.
//    - HOLD entries reload hold_cnt.
//    - Simultaneous events: only the highest-priority cause is recorded.
//  rst_out and running are registered from the next state. Event in RUN at edge N -> rst_out=1 after edge N.
//  Latency:
//   - clk_ok fall -> rst_out=1 within SYNC_STAGES+1 edges.
//   - Lock re-acquired -> rst_out=0 after SYNC_STAGES+HOLD_CYCLES+1 edges.
//  rst_cause:
//   - Written only on RUN exits; events in WAIT_LOCK/HOLD do not modify it.
//   - Holds value across HOLD; readable after release.
//  wd_trig/sw_rst outside RUN: only extend HOLD; never lost as glitches, never change cause.
//  rst_out never pulses shorter than HOLD_CYCLES; no combinational path from any input to rst_out.
// TESTING
//  T1 POR:
//   - rst=1 for 3 cycles, clk_ok=1 -> rst_out=1 through SYNC_STAGES+HOLD_CYCLES+1 edges after rst falls.
//   - Then rst_out=0, running=1, rst_cause=0.
//  T2 lock loss:
//   - In RUN, clk_ok=0 for 5 cycles -> rst_out=1 by edge 3, rst_cause=1.
//   - After clk_ok=1, rst_out=0 exactly 2+16+1 edges later.
//  T3 bounce (DEBOUNCE_CYCLES=8):
//   - btn_rst_n toggles every 3 cycles for 40 cycles -> no reset.
//   - Then held low 8+ cycles -> reset, rst_cause=2.
//   - Reset held while button stays low; released 16 cycles after btn_db clears.
//  T4 priority:
//   - In RUN, wd_trig and sw_rst in the same cycle -> rst_cause=3, one 16-cycle reset.
//  T5 extend:
//   - sw_rst pulse at HOLD cycle 10 -> hold restarts; total hold 27 cycles; rst_cause unchanged.
//  T6 mid-op rst:
//   - Assert rst during HOLD after a WD reset -> next edge WAIT_LOCK, rst_cause=0, counters zeroed.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Merges PLL lock loss, a debounced pushbutton, a watchdog expiry and a
//   software request into one registered, minimum-length system reset, and
//   records which source caused the most recent reset for the boot code.
//
// Ports
//   clk        in   system clock (PLL outclk 0)
//   rst        in   power-on reset, synchronous, active-high
//   clk_ok     in   PLL locked, asynchronous to clk
//   btn_rst_n  in   reset pushbutton, active-low, asynchronous, bouncing
//   wd_trig    in   watchdog expiry, 1-cycle pulse in clk domain
//   sw_rst     in   software reset request, 1-cycle pulse in clk domain
//   rst_out    out  system reset, active-high, registered
//   running    out  high only in RUN
//   rst_cause  out  last cause: 0=POR 1=LOCK 2=BTN 3=WD 4=SW
module reset_sequencer #(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_ok,
    input  logic       btn_rst_n,
    input  logic       wd_trig,
    input  logic       sw_rst,
    output logic       rst_out,
    output logic       running,
    output logic [2:0] rst_cause
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    localparam logic [2:0] C_POR  = 3'd0;
    localparam logic [2:0] C_LOCK = 3'd1;
    localparam logic [2:0] C_BTN  = 3'd2;
    localparam logic [2:0] C_WD   = 3'd3;
    localparam logic [2:0] C_SW   = 3'd4;

    // ---------------- synchronizers ----------------
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   lock_s;
    logic                   btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], clk_ok};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], ~btn_rst_n};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign btn_s  = btn_sync[SYNC_STAGES-1];

    // ---------------- debounce ----------------
    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    logic [DW-1:0] db_cnt;
    logic          btn_db;
    logic          btn_db_q;
    logic          btn_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign btn_press = btn_db & ~btn_db_q;

    // ---------------- sequencing FSM ----------------
    logic [1:0]    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [2:0]    cause_nxt;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        cause_nxt = rst_cause;
        case (state)
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_INIT;
                end
            end
            S_HOLD: begin
                // Any live source restarts the hold window; the cause is
                // left alone so the original RUN exit reason survives.
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (btn_db || wd_trig || sw_rst) begin
                    hold_nxt = HOLD_INIT;
                end else if (hold_cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    hold_nxt = hold_cnt - HW'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cause_nxt = C_LOCK;
                end else if (btn_press) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_INIT;
                    cause_nxt = C_BTN;
                end else if (wd_trig) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_INIT;
                    cause_nxt = C_WD;
                end else if (sw_rst) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_INIT;
                    cause_nxt = C_SW;
                end
            end
            default: begin
                state_nxt = S_WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from the next state so an event sampled at an
    // edge is visible on rst_out right after that same edge, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_LOCK;
            hold_cnt  <= '0;
            rst_cause <= C_POR;
            rst_out   <= 1'b1;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            rst_cause <= cause_nxt;
            rst_out   <= (state_nxt != S_RUN);
            running   <= (state_nxt == S_RUN);
        end
    end

endmodule
